mem_data_port: RTL and testbench
================================

# mem_data_port

Data-side memory responder: services the single outstanding load/store request issued by the store/load buffer and returns a completion pulse with raw load data. Sits between the store/load buffer and the 8-bit unified RAM/IO port. Serialises 1/2/4-byte accesses little-endian, honours IO back-pressure, and survives pipeline flushes.

## Interface
- `ADDR_W`, 32, byte address width.
- `IO_BASE`, 32'h30000, addresses ≥ this are IO.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global enable; low freezes all state.
- `Clear_flag` in 1: pipeline flush.
- `SLB_to_memctrl_needchange` in 1: load request pulse.
- `SLB_to_memctrl_needchange2` in 1: store request pulse.
- `SLB_to_memctrl_ordertype` in `INST_TYPE_WIDTH`: LB/LH/LW/LBU/LHU/SB/SH/SW.
- `SLB_to_memctrl_vj` in 32: base register value.
- `SLB_to_memctrl_vk` in 32: store data.
- `SLB_to_memctrl_A` in 32: immediate offset.
- `memctrl_data_ok` out 1: one-cycle completion pulse.
- `memctrl_data_ans` out 32: raw loaded bytes, zero-filled above access size (extension is done by the requester).
- `mem_din` in 8: RAM read data, valid the cycle after its address.
- `mem_dout` out 8: RAM write data.
- `mem_a` out `ADDR_W`: RAM byte address.
- `mem_wr` out 1: write strobe.
- `io_buffer_full` in 1: IO output buffer full.

## Operation
- Address = vj + A (mod 2^32); size n = 1/2/4 from ordertype.
- States: IDLE, READ, READ_TAIL, WRITE, DONE.
- IDLE + request (rdy high): latch addr, n, type, vk; idx←0; go READ or WRITE.
- READ: mem_a = addr+idx, mem_wr=0; from idx≥1, capture mem_din into byte idx−1 of the assembly register; after idx=n−1 go READ_TAIL.
- READ_TAIL: capture byte n−1; go DONE.
- WRITE: mem_a = addr+idx, mem_dout = vk byte idx, mem_wr=1; if addr+idx ≥ IO_BASE and io_buffer_full: mem_wr=0, idx holds. After byte n−1 is written go DONE.
- DONE: memctrl_data_ok=1 (unless suppressed), data_ans valid; go IDLE, or start the pending request.
- Pending slot: one entry. A request arriving while not IDLE is latched there and started from DONE. A second request with the slot full is a protocol violation (unchecked).
- Clear_flag: in-flight or pending load → discarded, return to IDLE next cycle, no data_ok. In-flight or pending store → completes all byte writes (it is committed) with data_ok suppressed. Load request in the same cycle as Clear_flag → dropped; store request in that cycle → accepted silently.
- rdy low: state, idx, and the pending slot hold; mem_wr forced 0; data_ok forced 0.
- Reset values: state IDLE, memctrl_data_ok 0, memctrl_data_ans 0, mem_a 0, mem_dout 0, mem_wr 0, pending empty.

## Timing
- Request sampled at the end of cycle T.
- Load, n bytes: address cycles T+1..T+n; data_ok in T+n+2 (LB T+3, LW T+6).
- Store, n bytes, no IO stall: write cycles T+1..T+n; data_ok in T+n+1 (SW T+5). Each stalled cycle adds 1.
- memctrl_data_ans holds its value until the next load completes.
- IDLE outputs: mem_wr 0, mem_a 0.
- Pending start: first address cycle immediately follows DONE.

## Structure
- Shared package `memctrl_pkg`: ordertype codes (common with decoder and buffers), `IO_BASE`, state enum, `size_of(ordertype)` function.
- No sub-module; one FSM plus datapath registers.

## Test plan
- LW, vj=0x100, A=4, RAM[0x104..0x107]=11 22 33 44 → mem_a 0x104..0x107 in T+1..T+4; data_ok T+6, data_ans 0x44332211.
- SH, vj=0x200, A=−2, vk=0xABCD1234 → writes 0x34@0x1FE, 0x12@0x1FF in T+1..T+2; data_ok T+3.
- SB to 0x30000, vk=0x41, io_buffer_full high for 3 cycles → mem_wr 0 for 3 cycles, then one write; data_ok T+5.
- LB at 0x10 with Clear_flag in T+1 → no data_ok; IDLE at T+2; next LBU accepted normally.
- SW issued with Clear_flag, then LW in T+2 → all 4 store bytes written with no data_ok; LW held pending, starts after store DONE, single data_ok.
- LH with rdy low in cycles T+2..T+4 → outputs frozen, mem_wr 0; data_ok delayed by exactly 3 cycles with correct data.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared definitions for the data-side memory controller: order types,
// IO window base, FSM states and the request record kept in flight/pending.
package memctrl_pkg;

  localparam int INST_TYPE_WIDTH = 4;
  typedef logic [INST_TYPE_WIDTH-1:0] ordertype_t;

  localparam ordertype_t OP_LB  = 4'd1;
  localparam ordertype_t OP_LH  = 4'd2;
  localparam ordertype_t OP_LW  = 4'd3;
  localparam ordertype_t OP_LBU = 4'd4;
  localparam ordertype_t OP_LHU = 4'd5;
  localparam ordertype_t OP_SB  = 4'd6;
  localparam ordertype_t OP_SH  = 4'd7;
  localparam ordertype_t OP_SW  = 4'd8;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_READ_TAIL,
    ST_WRITE,
    ST_DONE
  } state_e;

  // One memory operation: direction, completion suppression, last byte index.
  typedef struct packed {
    logic        store;
    logic        sup;
    logic [1:0]  last;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  function automatic logic [2:0] size_of(input ordertype_t t);
    case (t)
      OP_LB, OP_LBU, OP_SB: size_of = 3'd1;
      OP_LH, OP_LHU, OP_SH: size_of = 3'd2;
      default:              size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_port.sv
// Data-side memory responder: serialises one load/store (plus one pending)
// onto the 8-bit RAM/IO port, little-endian, with IO back-pressure and flush.
module mem_data_port
  import memctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = memctrl_pkg::IO_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              Clear_flag,
  input  logic              SLB_to_memctrl_needchange,
  input  logic              SLB_to_memctrl_needchange2,
  input  ordertype_t        SLB_to_memctrl_ordertype,
  input  logic [31:0]       SLB_to_memctrl_vj,
  input  logic [31:0]       SLB_to_memctrl_vk,
  input  logic [31:0]       SLB_to_memctrl_A,
  output logic              memctrl_data_ok,
  output logic [31:0]       memctrl_data_ans,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  req_t        cur_q, cur_d;
  req_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] ans_q, ans_d;
  logic        rd_vld_q, rd_vld_d;
  logic [1:0]  rd_byte_q, rd_byte_d;

  logic        clr;
  logic        new_vld;
  req_t        new_req;
  logic        pend_live;
  req_t        pend_eff;
  logic [31:0] cur_addr;
  logic        stall;
  logic        start;
  logic        launch;

  assign clr      = rdy & Clear_flag;
  assign cur_addr = cur_q.addr + 32'(idx_q);
  assign stall    = (cur_addr >= IO_BASE) & io_buffer_full;

  // A flushed load request is dropped; a store is always accepted.
  assign new_vld = rdy & (SLB_to_memctrl_needchange2 |
                          (SLB_to_memctrl_needchange & ~Clear_flag));

  always_comb begin
    new_req.store = SLB_to_memctrl_needchange2;
    new_req.sup   = Clear_flag;
    new_req.last  = 2'(size_of(SLB_to_memctrl_ordertype) - 3'd1);
    new_req.addr  = SLB_to_memctrl_vj + SLB_to_memctrl_A;
    new_req.data  = SLB_to_memctrl_vk;
  end

  // Flush kills a waiting load but only silences a waiting store.
  assign pend_live = pend_vld_q & ~(clr & ~pend_q.store);
  always_comb begin
    pend_eff     = pend_q;
    pend_eff.sup = pend_q.sup | clr;
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      ST_READ: mem_a = ADDR_W'(cur_addr);
      ST_WRITE: begin
        mem_a    = ADDR_W'(cur_addr);
        mem_dout = cur_q.data[{idx_q, 3'b000} +: 8];
        mem_wr   = rdy & ~stall;
      end
      default: ;
    endcase
  end

  assign memctrl_data_ok  = (state_q == ST_DONE) & rdy & ~cur_q.sup & ~Clear_flag;
  assign memctrl_data_ans = ans_q;

  // NOTE: every always_comb target gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ans_d      = ans_q;
    start      = 1'b0;
    launch     = 1'b0;
    rd_vld_d   = rdy & (state_q == ST_READ);
    rd_byte_d  = idx_q;

    // RAM data returns one cycle after an issued address regardless of rdy,
    // so capture is keyed to the issuing cycle rather than the current one.
    asm_d = asm_q;
    if (rd_vld_q) asm_d[{rd_byte_q, 3'b000} +: 8] = mem_din;

    if (rdy) begin
      case (state_q)
        ST_IDLE: start = 1'b1;
        ST_READ: begin
          if (clr) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else if (idx_q == cur_q.last) begin
            state_d = ST_READ_TAIL;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        ST_READ_TAIL: begin
          if (clr) begin
            state_d = ST_IDLE;
          end else begin
            ans_d   = asm_d;
            state_d = ST_DONE;
          end
        end
        ST_WRITE: begin
          if (clr) cur_d.sup = 1'b1;
          if (!stall) begin
            if (idx_q == cur_q.last) state_d = ST_DONE;
            else                     idx_d   = idx_q + 2'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          start   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (start && pend_live) begin
        cur_d      = pend_eff;
        launch     = 1'b1;
        pend_vld_d = new_vld;
        pend_d     = new_req;
      end else if (start && new_vld) begin
        cur_d      = new_req;
        launch     = 1'b1;
        pend_vld_d = 1'b0;
      end else if (new_vld) begin
        pend_vld_d = 1'b1;
        pend_d     = new_req;
      end else begin
        pend_vld_d = pend_live;
        pend_d     = pend_eff;
      end

      if (launch) begin
        idx_d   = '0;
        state_d = cur_d.store ? ST_WRITE : ST_READ;
        if (!cur_d.store) asm_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      asm_q      <= '0;
      ans_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      asm_q      <= asm_d;
      ans_q      <= ans_d;
      rd_vld_q   <= rd_vld_d;
      rd_byte_q  <= rd_byte_d;
    end
  end

endmodule

// File: tb/tb_mem_data_port.sv
// Directed bench for mem_data_port: cycle-by-cycle port checks against
// hand-computed expectations, with a small registered RAM model.
module tb_mem_data_port;
  import memctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        Clear_flag;
  logic        ld;
  logic        st;
  ordertype_t  otype;
  logic [31:0] vj, vk, a;
  logic        data_ok;
  logic [31:0] data_ans;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  int passed;
  int total;
  logic [7:0] ram [0:1023];

  mem_data_port #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .rdy                        (rdy),
    .Clear_flag                 (Clear_flag),
    .SLB_to_memctrl_needchange  (ld),
    .SLB_to_memctrl_needchange2 (st),
    .SLB_to_memctrl_ordertype   (otype),
    .SLB_to_memctrl_vj          (vj),
    .SLB_to_memctrl_vk          (vk),
    .SLB_to_memctrl_A           (a),
    .memctrl_data_ok            (data_ok),
    .memctrl_data_ans           (data_ans),
    .mem_din                    (mem_din),
    .mem_dout                   (mem_dout),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr),
    .io_buffer_full             (io_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[9:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ld         = 1'b0;
    st         = 1'b0;
    Clear_flag = 1'b0;
  endtask

  task automatic req(input logic is_st, input ordertype_t t, input logic [31:0] b,
                     input logic [31:0] off, input logic [31:0] d, input logic flush);
    ld         = ~is_st;
    st         = is_st;
    otype      = t;
    vj         = b;
    a          = off;
    vk         = d;
    Clear_flag = flush;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oks;
    logic [31:0] exp_a;
    passed = 0;
    total  = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h104] = 8'h11; ram[10'h105] = 8'h22; ram[10'h106] = 8'h33; ram[10'h107] = 8'h44;
    ram[10'h010] = 8'h9C;
    ram[10'h040] = 8'h01; ram[10'h041] = 8'h02; ram[10'h042] = 8'h03; ram[10'h043] = 8'h04;
    ram[10'h050] = 8'h77; ram[10'h051] = 8'h88;

    rst_n = 1'b0; rdy = 1'b1; Clear_flag = 1'b0; ld = 1'b0; st = 1'b0;
    otype = OP_LB; vj = '0; vk = '0; a = '0; io_full = 1'b0;

    #2;
    check("rst data_ok", 32'(data_ok), 32'd0);
    check("rst data_ans", data_ans, 32'd0);
    check("rst mem_a", mem_a, 32'd0);
    check("rst mem_dout", 32'(mem_dout), 32'd0);
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    #10 rst_n = 1'b1;

    // LW 0x100+4
    cyc();
    req(1'b0, OP_LW, 32'h100, 32'd4, 32'd0, 1'b0);
    #1;
    check("idle mem_a", mem_a, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      if (k <= 4) check($sformatf("lw mem_a k%0d", k), mem_a, 32'h104 + 32'(k - 1));
      check($sformatf("lw mem_wr k%0d", k), 32'(mem_wr), 32'd0);
      check($sformatf("lw data_ok k%0d", k), 32'(data_ok), 32'(k == 6));
      if (k >= 6) check($sformatf("lw data_ans k%0d", k), data_ans, 32'h4433_2211);
    end

    // SH 0x200-2
    req(1'b1, OP_SH, 32'h200, 32'hFFFF_FFFE, 32'hABCD_1234, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      check($sformatf("sh mem_wr k%0d", k), 32'(mem_wr), 32'(k <= 2));
      if (k == 1) begin
        check("sh mem_a b0", mem_a, 32'h1FE);
        check("sh mem_dout b0", 32'(mem_dout), 32'h34);
      end
      if (k == 2) begin
        check("sh mem_a b1", mem_a, 32'h1FF);
        check("sh mem_dout b1", 32'(mem_dout), 32'h12);
      end
      check($sformatf("sh data_ok k%0d", k), 32'(data_ok), 32'(k == 3));
    end
    check("sh ans held", data_ans, 32'h4433_2211);

    // SB to IO with back-pressure
    req(1'b1, OP_SB, 32'h0003_0000, 32'd0, 32'h0000_0041, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      io_full = (k <= 3);
      #1;
      check($sformatf("io mem_wr k%0d", k), 32'(mem_wr), 32'(k == 4));
      if (k <= 4) check($sformatf("io mem_a k%0d", k), mem_a, 32'h0003_0000);
      if (k == 4) check("io mem_dout", 32'(mem_dout), 32'h41);
      check($sformatf("io data_ok k%0d", k), 32'(data_ok), 32'(k == 5));
    end
    io_full = 1'b0;

    // LB flushed in T+1, then LBU accepted
    req(1'b0, OP_LB, 32'h10, 32'd0, 32'd0, 1'b0);
    cyc();
    Clear_flag = 1'b1;
    #1;
    check("flush data_ok T1", 32'(data_ok), 32'd0);
    cyc(); #1;
    check("flush idle mem_a", mem_a, 32'd0);
    check("flush data_ok T2", 32'(data_ok), 32'd0);
    check("flush ans held", data_ans, 32'h4433_2211);
    req(1'b0, OP_LBU, 32'h10, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      if (k == 1) check("lbu mem_a", mem_a, 32'h10);
      check($sformatf("lbu data_ok k%0d", k), 32'(data_ok), 32'(k == 3));
      if (k == 3) check("lbu data_ans", data_ans, 32'h0000_009C);
    end

    // SW issued with flush, LW arrives in T+2 and waits in the pending slot
    req(1'b1, OP_SW, 32'h20, 32'd0, 32'hDEAD_BEEF, 1'b1);
    oks = 0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 2) req(1'b0, OP_LW, 32'h40, 32'd0, 32'd0, 1'b0);
      #1;
      check($sformatf("swlw mem_wr k%0d", k), 32'(mem_wr), 32'(k <= 4));
      if (k <= 4) begin
        check($sformatf("swlw st mem_a k%0d", k), mem_a, 32'h20 + 32'(k - 1));
        exp_a = 32'hDEAD_BEEF >> (8 * (k - 1));
        check($sformatf("swlw st mem_dout k%0d", k), 32'(mem_dout), exp_a & 32'hFF);
      end
      if (k >= 6 && k <= 9) check($sformatf("swlw ld mem_a k%0d", k), mem_a, 32'h40 + 32'(k - 6));
      if (data_ok) oks++;
      if (k == 11) begin
        check("swlw data_ok T11", 32'(data_ok), 32'd1);
        check("swlw data_ans", data_ans, 32'h0403_0201);
      end
    end
    check("swlw data_ok count", 32'(oks), 32'd1);

    // LH with rdy low in T+2..T+4
    req(1'b0, OP_LH, 32'h50, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      rdy = !(k >= 2 && k <= 4);
      #1;
      check($sformatf("lh mem_wr k%0d", k), 32'(mem_wr), 32'd0);
      if (k == 1) check("lh mem_a k1", mem_a, 32'h50);
      if (k >= 2 && k <= 5) check($sformatf("lh mem_a k%0d", k), mem_a, 32'h51);
      check($sformatf("lh data_ok k%0d", k), 32'(data_ok), 32'(k == 7));
      if (k == 7) check("lh data_ans", data_ans, 32'h0000_8877);
    end
    rdy = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
